// File: rtl/clock_ctrl_pkg.sv
// Shared state codes, field limits and wrap helpers for the time-setting controller.
package clock_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_SET_H = 3'd1,
        ST_SET_M = 3'd2,
        ST_SET_S = 3'd3,
        ST_AL_H  = 3'd4,
        ST_AL_M  = 3'd5
    } state_t;

    localparam logic [6:0] HOUR_MAX       = 7'd23;
    localparam logic [6:0] MIN_MAX        = 7'd59;
    localparam logic [6:0] SEC_MAX        = 7'd59;
    localparam logic [6:0] ALARM_HOUR_RST = 7'd7;

    // Anything at or above the limit (including out-of-range captures) wraps to zero.
    function automatic logic [6:0] inc_wrap(input logic [6:0] v, input logic [6:0] lim);
        return (v >= lim) ? 7'd0 : v + 7'd1;
    endfunction

    function automatic logic [6:0] dec_wrap(input logic [6:0] v, input logic [6:0] lim);
        return (v == 7'd0) ? lim : v - 7'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchroniser, debounce filter and press/auto-repeat pulse generator for one
// active-low push-button.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter bit REPEAT_EN       = 1'b0,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 150
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pulse
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RMAX + 1);
    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic          sync1;
    logic          sync2;
    logic          pressed;
    logic          rep_phase;
    logic [DW-1:0] db_cnt;
    logic [RW-1:0] rep_cnt;
    logic          sample_low;
    logic          accept;

    assign sample_low = ~sync2;
    assign accept     = (sample_low != pressed) && (db_cnt == DB_LAST);

    // Debounced level tracking plus press and repeat pulse generation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            pressed   <= 1'b0;
            db_cnt    <= '0;
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
            pulse     <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            pulse <= 1'b0;
            if (accept) begin
                pressed   <= sample_low;
                db_cnt    <= '0;
                rep_cnt   <= '0;
                rep_phase <= 1'b0;
                pulse     <= sample_low;
            end else if (sample_low != pressed) begin
                db_cnt <= db_cnt + 1'b1;
            end else begin
                db_cnt <= '0;
            end

            // The edge that accepts a release never emits a repeat.
            if (REPEAT_EN && pressed && !accept) begin
                if (!rep_phase) begin
                    if (rep_cnt == DELAY_LAST) begin
                        pulse     <= 1'b1;
                        rep_cnt   <= '0;
                        rep_phase <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
                end else if (rep_cnt == PERIOD_LAST) begin
                    pulse   <= 1'b1;
                    rep_cnt <= '0;
                end else begin
                    rep_cnt <= rep_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Three-key time/alarm editor: edits a copy of the running time, loads it back
// to the timekeeping core, and owns the alarm registers and ring detection.
module time_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 150,
    parameter int TIMEOUT_CYCLES  = 10000
) (
    input  logic       clk_1KHZ,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_up,
    input  logic       key_down,
    input  logic [6:0] hour_in,
    input  logic [6:0] min_in,
    input  logic [6:0] sec_in,
    output logic       load,
    output logic [6:0] hour_set,
    output logic [6:0] min_set,
    output logic [6:0] sec_set,
    output logic [2:0] edit_field,
    output logic [6:0] disp_hour,
    output logic [6:0] disp_min,
    output logic [6:0] disp_sec,
    output logic       alarm_en,
    output logic       alarm_ring
);

    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic          mode_p;
    logic          up_p;
    logic          down_p;
    logic          up_ev;
    logic          down_ev;
    logic          any_p;
    logic          in_run;
    logic          ring_clear;
    logic          alarm_hit;
    logic [IW-1:0] idle_cnt;
    logic [6:0]    edit_hour;
    logic [6:0]    edit_min;
    logic [6:0]    edit_sec;
    logic [6:0]    alarm_hour;
    logic [6:0]    alarm_min;
    logic [6:0]    sec_prev;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b0),
                   .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_key_mode (.clk(clk_1KHZ), .rst(rst), .key_n(key_mode), .pulse(mode_p));

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b1),
                   .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_key_up (.clk(clk_1KHZ), .rst(rst), .key_n(key_up), .pulse(up_p));

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b1),
                   .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_key_down (.clk(clk_1KHZ), .rst(rst), .key_n(key_down), .pulse(down_p));

    // Mode beats up/down; up and down together cancel each other.
    assign up_ev      = up_p & ~down_p & ~mode_p;
    assign down_ev    = down_p & ~up_p & ~mode_p;
    assign any_p      = mode_p | up_p | down_p;
    assign in_run     = (state == ST_RUN);
    assign edit_field = state;
    assign ring_clear = (in_run && down_ev) || (in_run && up_ev && alarm_en) || (min_in != alarm_min);
    assign alarm_hit  = (sec_prev != 7'd0) && (sec_in == 7'd0) && alarm_en &&
                        (hour_in == alarm_hour) && (min_in == alarm_min);

    // Edit state machine, edit/alarm registers, load strobe and idle timeout.
    always_ff @(posedge clk_1KHZ or posedge rst) begin
        if (rst) begin
            state      <= ST_RUN;
            idle_cnt   <= '0;
            load       <= 1'b0;
            hour_set   <= 7'd0;
            min_set    <= 7'd0;
            sec_set    <= 7'd0;
            edit_hour  <= 7'd0;
            edit_min   <= 7'd0;
            edit_sec   <= 7'd0;
            alarm_hour <= ALARM_HOUR_RST;
            alarm_min  <= 7'd0;
            alarm_en   <= 1'b0;
        end else begin
            load <= 1'b0;
            if (state > ST_AL_M) begin
                state    <= ST_RUN;
                idle_cnt <= '0;
            end else if (!in_run && !any_p) begin
                if (idle_cnt == IDLE_LAST) begin
                    state    <= ST_RUN;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
                case (state)
                    ST_RUN: begin
                        if (mode_p) begin
                            state     <= ST_SET_H;
                            edit_hour <= hour_in;
                            edit_min  <= min_in;
                            edit_sec  <= sec_in;
                        end else if (up_ev) begin
                            alarm_en <= ~alarm_en;
                        end
                    end
                    ST_SET_H: begin
                        if (mode_p)       state     <= ST_SET_M;
                        else if (up_ev)   edit_hour <= inc_wrap(edit_hour, HOUR_MAX);
                        else if (down_ev) edit_hour <= dec_wrap(edit_hour, HOUR_MAX);
                    end
                    ST_SET_M: begin
                        if (mode_p)       state    <= ST_SET_S;
                        else if (up_ev)   edit_min <= inc_wrap(edit_min, MIN_MAX);
                        else if (down_ev) edit_min <= dec_wrap(edit_min, MIN_MAX);
                    end
                    ST_SET_S: begin
                        if (mode_p) begin
                            state    <= ST_AL_H;
                            load     <= 1'b1;
                            hour_set <= edit_hour;
                            min_set  <= edit_min;
                            sec_set  <= edit_sec;
                        end else if (up_ev) begin
                            edit_sec <= inc_wrap(edit_sec, SEC_MAX);
                        end else if (down_ev) begin
                            edit_sec <= dec_wrap(edit_sec, SEC_MAX);
                        end
                    end
                    ST_AL_H: begin
                        if (mode_p)       state      <= ST_AL_M;
                        else if (up_ev)   alarm_hour <= inc_wrap(alarm_hour, HOUR_MAX);
                        else if (down_ev) alarm_hour <= dec_wrap(alarm_hour, HOUR_MAX);
                    end
                    ST_AL_M: begin
                        if (mode_p)       state     <= ST_RUN;
                        else if (up_ev)   alarm_min <= inc_wrap(alarm_min, MIN_MAX);
                        else if (down_ev) alarm_min <= dec_wrap(alarm_min, MIN_MAX);
                    end
                    default: state <= ST_RUN;
                endcase
            end
        end
    end

    // Alarm ring latch; any clear condition takes priority over a new match.
    always_ff @(posedge clk_1KHZ or posedge rst) begin
        if (rst) begin
            alarm_ring <= 1'b0;
            sec_prev   <= 7'd0;
        end else begin
            sec_prev <= sec_in;
            if (ring_clear)     alarm_ring <= 1'b0;
            else if (alarm_hit) alarm_ring <= 1'b1;
            else                alarm_ring <= alarm_ring;
        end
    end

    // Registered display source selection.
    always_ff @(posedge clk_1KHZ or posedge rst) begin
        if (rst) begin
            disp_hour <= 7'd0;
            disp_min  <= 7'd0;
            disp_sec  <= 7'd0;
        end else begin
            case (state)
                ST_SET_H, ST_SET_M, ST_SET_S: begin
                    disp_hour <= edit_hour;
                    disp_min  <= edit_min;
                    disp_sec  <= edit_sec;
                end
                ST_AL_H, ST_AL_M: begin
                    disp_hour <= alarm_hour;
                    disp_min  <= alarm_min;
                    disp_sec  <= 7'd0;
                end
                default: begin
                    disp_hour <= hour_in;
                    disp_min  <= min_in;
                    disp_sec  <= sec_in;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with a cycle-level behavioural reference model.
module tb_time_set_ctrl;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 5;
    localparam int TO = 200;

    logic       clk_1KHZ = 1'b0;
    logic       rst;
    logic       key_mode, key_up, key_down;
    logic [6:0] hour_in, min_in, sec_in;
    logic       load;
    logic [6:0] hour_set, min_set, sec_set;
    logic [2:0] edit_field;
    logic [6:0] disp_hour, disp_min, disp_sec;
    logic       alarm_en, alarm_ring;

    int total = 0;
    int bad = 0;
    int load_cnt = 0;
    int ld_h = 0, ld_m = 0, ld_s = 0;

    // reference model state
    int m_st, m_eh, m_em, m_es, m_ah, m_am, m_en, m_ring, m_load;
    int m_hs, m_ms, m_ss, m_dh, m_dm, m_ds, m_secprev, m_idle;
    int k_d1[3], k_d2[3], k_run[3], k_prs[3], k_hold[3], k_pulse[3];

    time_set_ctrl #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                    .TIMEOUT_CYCLES(TO)) dut (
        .clk_1KHZ(clk_1KHZ), .rst(rst),
        .key_mode(key_mode), .key_up(key_up), .key_down(key_down),
        .hour_in(hour_in), .min_in(min_in), .sec_in(sec_in),
        .load(load), .hour_set(hour_set), .min_set(min_set), .sec_set(sec_set),
        .edit_field(edit_field), .disp_hour(disp_hour), .disp_min(disp_min), .disp_sec(disp_sec),
        .alarm_en(alarm_en), .alarm_ring(alarm_ring)
    );

    always #5 clk_1KHZ = ~clk_1KHZ;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int wrap_step(input int v, input int lim, input bit up);
        if (up) return (v >= lim) ? 0 : v + 1;
        return (v == 0) ? lim : v - 1;
    endfunction

    task automatic model_step();
        int pm, pu, pd, up, dn, lim, raw[3];
        bit smp_low;
        if (rst) begin
            m_st = 0; m_eh = 0; m_em = 0; m_es = 0; m_ah = 7; m_am = 0; m_en = 0; m_ring = 0;
            m_load = 0; m_hs = 0; m_ms = 0; m_ss = 0; m_dh = 0; m_dm = 0; m_ds = 0;
            m_secprev = 0; m_idle = 0;
            for (int i = 0; i < 3; i++) begin
                k_d1[i] = 1; k_d2[i] = 1; k_run[i] = 0; k_prs[i] = 0; k_hold[i] = 0; k_pulse[i] = 0;
            end
            return;
        end
        pm = k_pulse[0]; pu = k_pulse[1]; pd = k_pulse[2];
        up = (pu != 0 && pd == 0 && pm == 0) ? 1 : 0;
        dn = (pd != 0 && pu == 0 && pm == 0) ? 1 : 0;
        if (m_st == 0) begin
            m_dh = hour_in; m_dm = min_in; m_ds = sec_in;
        end else if (m_st <= 3) begin
            m_dh = m_eh; m_dm = m_em; m_ds = m_es;
        end else begin
            m_dh = m_ah; m_dm = m_am; m_ds = 0;
        end
        if ((m_st == 0 && dn == 1) || (m_st == 0 && up == 1 && m_en == 1) || int'(min_in) != m_am)
            m_ring = 0;
        else if (m_secprev != 0 && sec_in == 0 && m_en == 1 && int'(hour_in) == m_ah && int'(min_in) == m_am)
            m_ring = 1;
        m_secprev = sec_in;
        m_load = 0;
        if (m_st != 0 && pm == 0 && pu == 0 && pd == 0) begin
            m_idle++;
            if (m_idle == TO) begin m_st = 0; m_idle = 0; end
        end else begin
            m_idle = 0;
            if (pm != 0) begin
                if (m_st == 0) begin m_eh = hour_in; m_em = min_in; m_es = sec_in; end
                if (m_st == 3) begin m_load = 1; m_hs = m_eh; m_ms = m_em; m_ss = m_es; end
                m_st = (m_st == 5) ? 0 : m_st + 1;
            end else if (up == 1 || dn == 1) begin
                lim = (m_st == 1 || m_st == 4) ? 23 : 59;
                case (m_st)
                    0: if (up == 1) m_en = 1 - m_en;
                    1: m_eh = wrap_step(m_eh, lim, up == 1);
                    2: m_em = wrap_step(m_em, lim, up == 1);
                    3: m_es = wrap_step(m_es, lim, up == 1);
                    4: m_ah = wrap_step(m_ah, lim, up == 1);
                    default: m_am = wrap_step(m_am, lim, up == 1);
                endcase
            end
        end
        raw[0] = key_mode; raw[1] = key_up; raw[2] = key_down;
        for (int i = 0; i < 3; i++) begin
            smp_low = (k_d2[i] == 0);
            k_d2[i] = k_d1[i];
            k_d1[i] = raw[i];
            k_pulse[i] = 0;
            if (int'(smp_low) != k_prs[i]) k_run[i]++; else k_run[i] = 0;
            if (k_run[i] == DB) begin
                k_prs[i] = smp_low; k_run[i] = 0;
                if (smp_low) begin k_pulse[i] = 1; k_hold[i] = 0; end
            end else if (k_prs[i] == 1 && i != 0) begin
                k_hold[i]++;
                if (k_hold[i] >= RD && (k_hold[i] - RD) % RP == 0) k_pulse[i] = 1;
            end
        end
    endtask

    always @(posedge clk_1KHZ or posedge rst) model_step();

    // per-cycle comparison against the model plus load capture
    always @(negedge clk_1KHZ) begin
        chk("edit_field", edit_field, m_st);
        chk("load", load, m_load);
        chk("hour_set", hour_set, m_hs);
        chk("min_set", min_set, m_ms);
        chk("sec_set", sec_set, m_ss);
        chk("disp_hour", disp_hour, m_dh);
        chk("disp_min", disp_min, m_dm);
        chk("disp_sec", disp_sec, m_ds);
        chk("alarm_en", alarm_en, m_en);
        chk("alarm_ring", alarm_ring, m_ring);
        if (load) begin
            load_cnt++; ld_h = hour_set; ld_m = min_set; ld_s = sec_set;
        end
    end

    task automatic set_key(input int k, input logic v);
        case (k)
            0: key_mode = v;
            1: key_up = v;
            default: key_down = v;
        endcase
    endtask

    task automatic press(input int k, input int n, input int gap);
        set_key(k, 1'b0);
        repeat (n) @(negedge clk_1KHZ);
        set_key(k, 1'b1);
        repeat (gap) @(negedge clk_1KHZ);
    endtask

    task automatic tap(input int k);
        press(k, 6, 14);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_1KHZ);
    endtask

    initial begin
        rst = 1'b1; key_mode = 1'b1; key_up = 1'b1; key_down = 1'b1;
        hour_in = 7'd11; min_in = 7'd59; sec_in = 7'd40;
        wait_cyc(3);
        chk("rst_disp_hour", disp_hour, 0);
        chk("rst_edit_field", edit_field, 0);
        rst = 1'b0;
        wait_cyc(1);
        chk("run_disp_hour", disp_hour, 11);

        // debounce: short and bouncy presses are ignored, 4 samples accepted once
        press(1, 3, 14);
        chk("short_press", alarm_en, 0);
        press(1, 2, 1);
        press(1, 3, 14);
        chk("bounce_press", alarm_en, 0);
        press(1, 4, 14);
        chk("four_low_press", alarm_en, 1);
        tap(1);
        chk("toggle_back", alarm_en, 0);

        // edit 11:59:40 -> 12:59:39 and load
        load_cnt = 0;
        tap(0); tap(1); tap(0); tap(0); tap(2); tap(0);
        chk("load_count", load_cnt, 1);
        chk("load_hour", ld_h, 12);
        chk("load_min", ld_m, 59);
        chk("load_sec", ld_s, 39);
        chk("after_load_state", edit_field, 4);
        tap(0); tap(0);
        chk("back_to_run", edit_field, 0);

        // wrap boundaries and up+down cancellation
        hour_in = 7'd0; min_in = 7'd59; sec_in = 7'd0;
        tap(0); tap(2);
        chk("hour_wrap_down", disp_hour, 23);
        tap(0); tap(1);
        chk("min_wrap_up", disp_min, 0);
        key_up = 1'b0; key_down = 1'b0;
        wait_cyc(6);
        key_up = 1'b1; key_down = 1'b1;
        wait_cyc(14);
        chk("up_down_cancel", disp_min, 0);
        tap(0); tap(0); tap(0); tap(0);
        chk("run_again", edit_field, 0);

        // idle timeout from SET_M
        load_cnt = 0;
        tap(0); tap(0);
        wait_cyc(150);
        chk("still_set_m", edit_field, 2);
        wait_cyc(60);
        chk("timeout_run", edit_field, 0);
        chk("timeout_no_load", load_cnt, 0);

        // alarm ring at 07:00
        tap(1);
        chk("alarm_armed", alarm_en, 1);
        hour_in = 7'd7; min_in = 7'd0; sec_in = 7'd59;
        wait_cyc(2);
        sec_in = 7'd0;
        wait_cyc(2);
        chk("ring_set", alarm_ring, 1);
        tap(2);
        chk("ring_clr_down", alarm_ring, 0);
        wait_cyc(10);
        chk("ring_stays_clear", alarm_ring, 0);
        sec_in = 7'd1; wait_cyc(2); sec_in = 7'd0; wait_cyc(2);
        chk("ring_reset", alarm_ring, 1);
        min_in = 7'd1; wait_cyc(2);
        chk("ring_clr_min", alarm_ring, 0);
        min_in = 7'd0; sec_in = 7'd1; wait_cyc(2); sec_in = 7'd0; wait_cyc(2);
        chk("ring_third", alarm_ring, 1);
        tap(1);
        chk("ring_clr_disarm", alarm_ring, 0);

        // auto-repeat in AL_M: release is recognised 40 cycles after key-down
        tap(0); tap(0); tap(0); tap(0); tap(0);
        chk("in_al_m", edit_field, 5);
        press(1, 34, 14);
        chk("repeat_alarm_min", disp_min, 4);
        tap(0); tap(1); tap(0); tap(1);
        chk("mid_edit_state", edit_field, 1);

        // asynchronous reset in the middle of a cycle
        @(posedge clk_1KHZ);
        #2 rst = 1'b1;
        #1;
        chk("arst_state", edit_field, 0);
        chk("arst_load", load, 0);
        chk("arst_hour_set", hour_set, 0);
        chk("arst_disp_min", disp_min, 0);
        chk("arst_alarm_en", alarm_en, 0);
        chk("arst_ring", alarm_ring, 0);
        load_cnt = 0;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(30);
        chk("no_load_after_rst", load_cnt, 0);
        tap(0); tap(0); tap(0); tap(0);
        chk("alarm_hour_rst", disp_hour, 7);
        chk("alarm_min_rst", disp_min, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
